// File: rtl/hit_ctl.sv
// Player-hit and lives controller: qualifies collisions into hits and tracks lives.
// It also runs the post-hit invulnerability window with sprite blinking, and the game-over state.
module hit_ctl #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned INVUL_FRAMES = 120,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       collision,
  input  logic       frame_tick,
  input  logic       game_start,
  output logic [2:0] lives,
  output logic       hit,
  output logic       invulnerable,
  output logic       yoshi_visible,
  output logic       game_over
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_INVUL = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);
  localparam logic [7:0] INVUL_LOAD = 8'(INVUL_FRAMES);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic       hit_q, hit_d;
  logic       invul_q, invul_d;
  logic       vis_q, vis_d;
  logic       over_q, over_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       coll_q;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    hit_d       = 1'b0;
    invul_d     = invul_q;
    vis_d       = vis_q;
    over_d      = over_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;

    // A restart overrides any collision or frame event in the same cycle.
    if (game_start) begin
      state_d     = S_PLAY;
      lives_d     = LIVES_LOAD;
      invul_d     = 1'b0;
      vis_d       = 1'b1;
      over_d      = 1'b0;
      frame_cnt_d = 8'd0;
      blink_cnt_d = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
        end
        S_PLAY: begin
          if (coll_q) begin
            hit_d = 1'b1;
            // Last life goes straight to OVER so lives can never wrap.
            if (lives_q <= 3'd1) begin
              lives_d = 3'd0;
              state_d = S_OVER;
              over_d  = 1'b1;
              vis_d   = 1'b1;
            end else begin
              lives_d     = lives_q - 3'd1;
              state_d     = S_INVUL;
              invul_d     = 1'b1;
              vis_d       = 1'b0;
              frame_cnt_d = INVUL_LOAD;
              blink_cnt_d = 8'd0;
            end
          end
        end
        S_INVUL: begin
          if (frame_tick) begin
            if (frame_cnt_q == 8'd1) begin
              state_d     = S_PLAY;
              invul_d     = 1'b0;
              vis_d       = 1'b1;
              frame_cnt_d = 8'd0;
              blink_cnt_d = 8'd0;
            end else begin
              frame_cnt_d = frame_cnt_q - 8'd1;
              if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 8'd0;
                vis_d       = ~vis_q;
              end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
              end
            end
          end
        end
        S_OVER: begin
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lives_q     <= LIVES_LOAD;
      hit_q       <= 1'b0;
      invul_q     <= 1'b0;
      vis_q       <= 1'b1;
      over_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
      blink_cnt_q <= 8'd0;
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      hit_q       <= hit_d;
      invul_q     <= invul_d;
      vis_q       <= vis_d;
      over_q      <= over_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      coll_q      <= collision;
    end
  end

  assign lives         = lives_q;
  assign hit           = hit_q;
  assign invulnerable  = invul_q;
  assign yoshi_visible = vis_q;
  assign game_over     = over_q;

endmodule

// File: tb/tb_hit_ctl.sv
// Directed self-checking bench for hit_ctl with default parameters (3 lives, 120 frames, blink 8).
module tb_hit_ctl;

  logic       pclk;
  logic       rst_n;
  logic       collision;
  logic       frame_tick;
  logic       game_start;
  logic [2:0] lives;
  logic       hit;
  logic       invulnerable;
  logic       yoshi_visible;
  logic       game_over;

  int tests;
  int failures;

  hit_ctl #(.LIVES_INIT(3), .INVUL_FRAMES(120), .BLINK_FRAMES(8)) dut (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .collision     (collision),
    .frame_tick    (frame_tick),
    .game_start    (game_start),
    .lives         (lives),
    .hit           (hit),
    .invulnerable  (invulnerable),
    .yoshi_visible (yoshi_visible),
    .game_over     (game_over)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic tick_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
    end
  endtask

  task automatic start_game();
    game_start = 1'b1;
    step(1);
    game_start = 1'b0;
  endtask

  // Leaves the bench right after the edge where a resulting hit is visible.
  task automatic pulse_collision();
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; collision = 1'b0; frame_tick = 1'b0; game_start = 1'b0;
    step(2);
    tests++; if (lives !== 3'd3) begin failures++; $display("[TB] FAIL reset_lives: got %0d expected 3", lives); end
    tests++; if (yoshi_visible !== 1'b1) begin failures++; $display("[TB] FAIL reset_visible: got %0b expected 1", yoshi_visible); end
    tests++; if (hit !== 1'b0 || game_over !== 1'b0 || invulnerable !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_flags: got hit=%0b over=%0b invul=%0b expected 0 0 0", hit, game_over, invulnerable);
    end
    rst_n = 1'b1;
    step(1);
    pulse_collision();
    tests++; if (hit !== 1'b0) begin failures++; $display("[TB] FAIL idle_no_hit: got %0b expected 0", hit); end
    step(1);
    tests++; if (lives !== 3'd3 || hit !== 1'b0) begin failures++; $display("[TB] FAIL idle_lives: got lives=%0d hit=%0b expected 3 0", lives, hit); end
  endtask

  task automatic test_single_hit();
    start_game();
    tests++; if (lives !== 3'd3 || game_over !== 1'b0) begin failures++; $display("[TB] FAIL start_lives: got %0d expected 3", lives); end
    pulse_collision();
    tests++; if (hit !== 1'b1) begin failures++; $display("[TB] FAIL single_hit_pulse: got %0b expected 1", hit); end
    tests++; if (lives !== 3'd2) begin failures++; $display("[TB] FAIL single_hit_lives: got %0d expected 2", lives); end
    tests++; if (invulnerable !== 1'b1 || yoshi_visible !== 1'b0) begin
      failures++; $display("[TB] FAIL single_hit_invul: got invul=%0b vis=%0b expected 1 0", invulnerable, yoshi_visible);
    end
    step(1);
    tests++; if (hit !== 1'b0) begin failures++; $display("[TB] FAIL single_hit_fall: got %0b expected 0", hit); end
    tick_frames(7);
    tests++; if (yoshi_visible !== 1'b0) begin failures++; $display("[TB] FAIL blink_7: got %0b expected 0", yoshi_visible); end
    tick_frames(1);
    tests++; if (yoshi_visible !== 1'b1) begin failures++; $display("[TB] FAIL blink_8: got %0b expected 1", yoshi_visible); end
    tick_frames(111);
    tests++; if (invulnerable !== 1'b1 || yoshi_visible !== 1'b0) begin
      failures++; $display("[TB] FAIL invul_119: got invul=%0b vis=%0b expected 1 0", invulnerable, yoshi_visible);
    end
    tick_frames(1);
    tests++; if (invulnerable !== 1'b0 || yoshi_visible !== 1'b1 || lives !== 3'd2) begin
      failures++; $display("[TB] FAIL invul_end: got invul=%0b vis=%0b lives=%0d expected 0 1 2", invulnerable, yoshi_visible, lives);
    end
  endtask

  task automatic test_held_collision();
    int hits;
    hits = 0;
    start_game();
    collision = 1'b1;
    for (int i = 0; i < 800; i++) begin
      frame_tick = ((i % 4) == 3);
      step(1);
      if (hit === 1'b1) hits++;
    end
    frame_tick = 1'b0;
    collision = 1'b0;
    tests++; if (hits != 2) begin failures++; $display("[TB] FAIL held_hit_count: got %0d expected 2", hits); end
    tests++; if (lives !== 3'd1 || invulnerable !== 1'b1) begin
      failures++; $display("[TB] FAIL held_lives: got lives=%0d invul=%0b expected 1 1", lives, invulnerable);
    end
    step(2);
  endtask

  task automatic test_game_over();
    start_game();
    pulse_collision();
    tests++; if (lives !== 3'd2 || hit !== 1'b1) begin failures++; $display("[TB] FAIL over_hit1: got lives=%0d hit=%0b expected 2 1", lives, hit); end
    tick_frames(120);
    tests++; if (invulnerable !== 1'b0) begin failures++; $display("[TB] FAIL over_invul1_end: got %0b expected 0", invulnerable); end
    pulse_collision();
    tests++; if (lives !== 3'd1) begin failures++; $display("[TB] FAIL over_hit2: got %0d expected 1", lives); end
    tick_frames(120);
    pulse_collision();
    tests++; if (lives !== 3'd0 || hit !== 1'b1) begin failures++; $display("[TB] FAIL over_hit3: got lives=%0d hit=%0b expected 0 1", lives, hit); end
    tests++; if (game_over !== 1'b1 || invulnerable !== 1'b0 || yoshi_visible !== 1'b1) begin
      failures++; $display("[TB] FAIL over_state: got over=%0b invul=%0b vis=%0b expected 1 0 1", game_over, invulnerable, yoshi_visible);
    end
    step(1);
    tests++; if (hit !== 1'b0) begin failures++; $display("[TB] FAIL over_hit_fall: got %0b expected 0", hit); end
    pulse_collision();
    tests++; if (hit !== 1'b0 || lives !== 3'd0 || game_over !== 1'b1) begin
      failures++; $display("[TB] FAIL over_ignore: got hit=%0b lives=%0d over=%0b expected 0 0 1", hit, lives, game_over);
    end
    start_game();
    tests++; if (lives !== 3'd3 || game_over !== 1'b0) begin
      failures++; $display("[TB] FAIL over_restart: got lives=%0d over=%0b expected 3 0", lives, game_over);
    end
  endtask

  task automatic test_restart_priority();
    start_game();
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    game_start = 1'b1;
    step(1);
    game_start = 1'b0;
    tests++; if (hit !== 1'b0 || lives !== 3'd3) begin failures++; $display("[TB] FAIL restart_vs_hit: got hit=%0b lives=%0d expected 0 3", hit, lives); end
    step(1);
    tests++; if (hit !== 1'b0 || invulnerable !== 1'b0) begin failures++; $display("[TB] FAIL restart_after: got hit=%0b invul=%0b expected 0 0", hit, invulnerable); end
    pulse_collision();
    tick_frames(20);
    tests++; if (yoshi_visible !== 1'b0 || lives !== 3'd2) begin
      failures++; $display("[TB] FAIL restart_pre: got vis=%0b lives=%0d expected 0 2", yoshi_visible, lives);
    end
    start_game();
    tests++; if (invulnerable !== 1'b0 || yoshi_visible !== 1'b1 || lives !== 3'd3 || hit !== 1'b0) begin
      failures++; $display("[TB] FAIL restart_mid_invul: got invul=%0b vis=%0b lives=%0d hit=%0b expected 0 1 3 0", invulnerable, yoshi_visible, lives, hit);
    end
  endtask

  task automatic test_reset_mid_invul();
    int hits;
    hits = 0;
    start_game();
    pulse_collision();
    tick_frames(50);
    tests++; if (invulnerable !== 1'b1 || lives !== 3'd2 || yoshi_visible !== 1'b0) begin
      failures++; $display("[TB] FAIL pre_reset: got invul=%0b lives=%0d vis=%0b expected 1 2 0", invulnerable, lives, yoshi_visible);
    end
    rst_n = 1'b0;
    #2;
    tests++; if (lives !== 3'd3 || yoshi_visible !== 1'b1) begin
      failures++; $display("[TB] FAIL async_reset_vals: got lives=%0d vis=%0b expected 3 1", lives, yoshi_visible);
    end
    tests++; if (invulnerable !== 1'b0 || hit !== 1'b0 || game_over !== 1'b0) begin
      failures++; $display("[TB] FAIL async_reset_flags: got invul=%0b hit=%0b over=%0b expected 0 0 0", invulnerable, hit, game_over);
    end
    step(1);
    rst_n = 1'b1;
    collision = 1'b1;
    for (int i = 0; i < 20; i++) begin
      frame_tick = ((i % 2) == 1);
      step(1);
      if (hit === 1'b1) hits++;
    end
    frame_tick = 1'b0;
    collision = 1'b0;
    tests++; if (hits != 0 || lives !== 3'd3 || invulnerable !== 1'b0) begin
      failures++; $display("[TB] FAIL post_reset_idle: got hits=%0d lives=%0d invul=%0b expected 0 3 0", hits, lives, invulnerable);
    end
  endtask

  initial begin
    tests = 0;
    failures = 0;
    test_reset();
    test_single_hit();
    test_held_collision();
    test_game_over();
    test_restart_priority();
    test_reset_mid_invul();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
